// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the round-robin one-hot arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int RR_NUM_REQ  = 16;
    localparam int RR_MAX_HOLD = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-search: first set request at or above ptr, wrapping to 0.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ   = RR_NUM_REQ,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] idx,
    output logic [NUM_REQ-1:0]   onehot
);

    always_comb begin
        int                   pos;
        logic [IDX_WIDTH-1:0] pos_idx;
        found   = 1'b0;
        idx     = '0;
        onehot  = '0;
        pos     = 0;
        pos_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // Wrap at NUM_REQ, not at 2**IDX_WIDTH, so non-power-of-two counts work.
            pos = int'(ptr) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_idx = IDX_WIDTH'(pos);
            if (!found && req[pos_idx]) begin
                found           = 1'b1;
                idx             = pos_idx;
                onehot[pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant, binary index and hold-limit revoke.
// state | meaning
// IDLE  | no owner; pick next requester from ptr
// BUSY  | grant held until done, withdrawal or hold limit
module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ   = RR_NUM_REQ,
    parameter int IDX_WIDTH = $clog2(NUM_REQ),
    parameter int MAX_HOLD  = RR_MAX_HOLD,
    parameter int CNT_WIDTH = $clog2(MAX_HOLD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [IDX_WIDTH-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic                 timeout
);

    arb_state_t           r_state,     w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt,       w_gnt_nxt;
    logic [IDX_WIDTH-1:0] r_gnt_idx,   w_gnt_idx_nxt;
    logic [IDX_WIDTH-1:0] r_ptr,       w_ptr_nxt;
    logic [CNT_WIDTH-1:0] r_hold_cnt,  w_hold_cnt_nxt;
    logic                 r_gnt_valid, w_gnt_valid_nxt;
    logic                 r_timeout,   w_timeout_nxt;

    logic                 w_found;
    logic [IDX_WIDTH-1:0] w_pick_idx;
    logic [NUM_REQ-1:0]   w_pick_onehot;
    logic [IDX_WIDTH-1:0] w_ptr_wrap;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .found  (w_found),
        .idx    (w_pick_idx),
        .onehot (w_pick_onehot)
    );

    assign w_ptr_wrap = (r_gnt_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                                                              : r_gnt_idx + IDX_WIDTH'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_ptr_nxt       = r_ptr;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt_nxt       = w_pick_onehot;
                    w_gnt_idx_nxt   = w_pick_idx;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = CNT_WIDTH'(1);
                    w_state_nxt     = BUSY;
                end
            end
            BUSY: begin
                // done wins over the limit, so a same-cycle collision never flags timeout.
                if (done || !req[r_gnt_idx] || (r_hold_cnt == CNT_WIDTH'(MAX_HOLD))) begin
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_hold_cnt_nxt  = '0;
                    w_ptr_nxt       = w_ptr_wrap;
                    w_state_nxt     = IDLE;
                    w_timeout_nxt   = !done && req[r_gnt_idx];
                end else begin
                    w_hold_cnt_nxt  = r_hold_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
